alu_iterative: RTL and testbench

- Execute stage downstream of alu_op_decode: consumes the 4-bit alu_op plus two XLEN operands and produces the ALU result and a zero flag.
- Logic/arith/compare ops complete in one cycle.
- Shifts run one bit per cycle, trading latency for area.
- Valid/ready handshakes on input and output let the control FSM stall fetch/decode while a shift is in flight.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb.sv | 41 ++++
 rtl/alu_iterative.sv | 163 ++++++++++++++++
 tb/tb_alu_iterative.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_pkg                                               |
// | Brief    : Shared ALU opcode constants, FSM state encoding and   |
// |            shift-op predicate for alu_op_decode / alu_iterative. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package alu_pkg;

   localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
   localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
   localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
   localparam logic [3:0] ALU_OP_AND  = 4'b0100;
   localparam logic [3:0] ALU_OP_OR   = 4'b0101;
   localparam logic [3:0] ALU_OP_XOR  = 4'b0110;
   localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
   localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
   localparam logic [3:0] ALU_OP_SRA  = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } alu_state_t;

   // Upper opcode bit marks the shift group; 1010 and 11xx in that group
   // are undefined and must be filtered by the caller.
   function automatic logic is_shift_op(input logic [3:0] op);
      return op[3];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_comb                                              |
// | Brief    : Single-cycle non-shift datapath (add/sub/compare/     |
// |            logic). Undefined and shift codes produce zero.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module alu_comb
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result
);

   logic w_lt_signed;
   logic w_lt_unsigned;

   assign w_lt_signed   = ($signed(op_a) < $signed(op_b));
   assign w_lt_unsigned = (op_a < op_b);

   // Opcode-selected arithmetic/logic result, zero for anything else
   always_comb begin
      result = '0;
      case (alu_op)
         ALU_OP_ADD:  result = op_a + op_b;
         ALU_OP_SUB:  result = op_a - op_b;
         ALU_OP_SLT:  result = {{(XLEN-1){1'b0}}, w_lt_signed};
         ALU_OP_SLTU: result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
         ALU_OP_AND:  result = op_a & op_b;
         ALU_OP_OR:   result = op_a | op_b;
         ALU_OP_XOR:  result = op_a ^ op_b;
         default:     result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_iterative.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_iterative                                         |
// | Brief    : Execute-stage ALU with valid/ready handshakes. Non-   |
// |            shift ops finish in one cycle; shifts iterate one bit |
// |            per cycle unless ALU_BARREL_SHIFT_EN is defined, in   |
// |            which case a combinational barrel shifter is used.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module alu_iterative
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   alu_state_t         r_state;
   alu_state_t         w_state_nxt;
   logic [XLEN-1:0]    r_result;
   logic [XLEN-1:0]    w_result_nxt;
   logic [XLEN-1:0]    w_comb_result;
   logic [SHAMT_W-1:0] w_shamt;
   logic               w_accept;
   logic               w_is_shift;

   assign w_accept = in_valid && in_ready;
   assign w_shamt  = op_b[SHAMT_W-1:0];
   // Only SLL/SRL/SRA are real shifts; 1010 and 11xx fall to the zero path
   assign w_is_shift = is_shift_op(alu_op) && !alu_op[2] && (alu_op[1:0] != 2'b10);

   alu_comb #(
      .XLEN   (XLEN)
   ) u_alu_comb (
      .alu_op (alu_op),
      .op_a   (op_a),
      .op_b   (op_b),
      .result (w_comb_result)
   );

`ifdef ALU_BARREL_SHIFT_EN
   logic [XLEN-1:0] w_barrel;

   // Full-width shift in one cycle
   always_comb begin
      w_barrel = '0;
      case (alu_op)
         ALU_OP_SLL: w_barrel = op_a << w_shamt;
         ALU_OP_SRL: w_barrel = op_a >> w_shamt;
         ALU_OP_SRA: w_barrel = $signed(op_a) >>> w_shamt;
         default:    w_barrel = '0;
      endcase
   end
`else
   logic [XLEN-1:0]    r_work;
   logic [XLEN-1:0]    w_work_nxt;
   logic [XLEN-1:0]    w_work_step;
   logic [SHAMT_W-1:0] r_cnt;
   logic [SHAMT_W-1:0] w_cnt_nxt;
   logic [3:0]         r_sop;
   logic [3:0]         w_sop_nxt;

   // One-bit step of the working register for the latched shift kind
   always_comb begin
      w_work_step = r_work;
      case (r_sop)
         ALU_OP_SLL: w_work_step = {r_work[XLEN-2:0], 1'b0};
         ALU_OP_SRL: w_work_step = {1'b0, r_work[XLEN-1:1]};
         default:    w_work_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
      endcase
   end
`endif

   // Next-state and datapath-load decisions for the IDLE/SHIFT/DONE sequence
   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
`ifndef ALU_BARREL_SHIFT_EN
      w_work_nxt   = r_work;
      w_cnt_nxt    = r_cnt;
      w_sop_nxt    = r_sop;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_DONE;
`ifdef ALU_BARREL_SHIFT_EN
               w_result_nxt = w_is_shift ? w_barrel : w_comb_result;
`else
               if (w_is_shift) begin
                  w_work_nxt = op_a;
                  w_cnt_nxt  = w_shamt;
                  w_sop_nxt  = alu_op;
                  // A zero shift amount skips iteration entirely
                  if (w_shamt == '0) begin
                     w_result_nxt = op_a;
                  end else begin
                     w_state_nxt = ST_SHIFT;
                  end
               end else begin
                  w_result_nxt = w_comb_result;
               end
`endif
            end
         end
`ifndef ALU_BARREL_SHIFT_EN
         ST_SHIFT: begin
            w_work_nxt = w_work_step;
            w_cnt_nxt  = r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
               w_result_nxt = w_work_step;
               w_state_nxt  = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any shift in flight
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
`ifndef ALU_BARREL_SHIFT_EN
         r_work   <= '0;
         r_cnt    <= '0;
         r_sop    <= ALU_OP_ADD;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_result_nxt;
`ifndef ALU_BARREL_SHIFT_EN
         r_work   <= w_work_nxt;
         r_cnt    <= w_cnt_nxt;
         r_sop    <= w_sop_nxt;
`endif
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;
   assign zero      = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_alu_iterative                                      |
// | Brief    : Self-checking bench for alu_iterative: directed       |
// |            vector table, corner sequences, random ops vs model.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_alu_iterative;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int errors;
   int checks;

   alu_iterative #(
      .XLEN      (32)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Behavioural reference: operation semantics straight from the opcode table
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    return (a < b) ? 32'd1 : 32'd0;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd8:    return a << sh;
         4'd9:    return a >> sh;
         4'd11:   return 32'($signed(a) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      if ((op == 4'd8 || op == 4'd9 || op == 4'd11) && (b % 32) != 0)
         return int'(b % 32) + 1;
      return 1;
`endif
   endfunction

   // Issue one op, measure latency, check result, apply bp cycles of backpressure, release
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int bp, input string name);
      int   cyc;
      int   busy_bad;
      int   guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_op   = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      cyc      = 1;
      busy_bad = 0;
      while (!out_valid && cyc <= 40) begin
         if (in_ready) busy_bad++;
         @(posedge clk); #1;
         cyc++;
      end
      if (in_ready) busy_bad++;
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_latency"}, cyc, lat);
      chk({name, "_busy_ready_hi"}, busy_bad, 0);
      chk({name, "_result"}, result, exp);
      chk({name, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk({name, "_hold_result"}, result, exp);
         chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_release_valid"}, {31'd0, out_valid}, 32'd0);
      chk({name, "_release_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int          vcount;
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] corner [6];

      errors    = 0;
      checks    = 0;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = 4'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;

      tbl[0]  = '{op: 4'b0000, a: 32'h7FFF_FFFF, b: 32'h0000_0001, res: 32'h8000_0000, lat: 1};
      tbl[1]  = '{op: 4'b0001, a: 32'h0000_0005, b: 32'h0000_0005, res: 32'h0000_0000, lat: 1};
      tbl[2]  = '{op: 4'b0010, a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0001, lat: 1};
      tbl[3]  = '{op: 4'b0011, a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0000, lat: 1};
      tbl[4]  = '{op: 4'b1011, a: 32'h8000_0000, b: 32'h0000_0024, res: 32'hF800_0000, lat: 5};
      tbl[5]  = '{op: 4'b1000, a: 32'h0000_0001, b: 32'h0000_001F, res: 32'h8000_0000, lat: 32};
      tbl[6]  = '{op: 4'b1001, a: 32'h1234_5678, b: 32'hFFFF_FFE0, res: 32'h1234_5678, lat: 1};
      tbl[7]  = '{op: 4'b1100, a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0000, lat: 1};
      tbl[8]  = '{op: 4'b0111, a: 32'h1234_5678, b: 32'h0000_0003, res: 32'h0000_0000, lat: 1};
      tbl[9]  = '{op: 4'b1010, a: 32'h8000_0001, b: 32'h0000_0002, res: 32'h0000_0000, lat: 1};
      tbl[10] = '{op: 4'b0100, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, res: 32'hF000_F000, lat: 1};
      tbl[11] = '{op: 4'b0101, a: 32'h0F00_0000, b: 32'h0000_00F0, res: 32'h0F00_00F0, lat: 1};
      tbl[12] = '{op: 4'b1001, a: 32'h8000_0000, b: 32'h0000_001F, res: 32'h0000_0001, lat: 32};
      tbl[13] = '{op: 4'b1011, a: 32'h7FFF_FFFF, b: 32'h0000_0003, res: 32'h0FFF_FFFF, lat: 4};
`ifdef ALU_BARREL_SHIFT_EN
      foreach (tbl[i]) tbl[i].lat = 1;
`endif

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_zero", {31'd0, zero}, 32'd1);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 0, $sformatf("vec%0d", i));
      end

      // Result held under backpressure
      run_op(4'b0110, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1, 3, "xor_bp");

      // Reset while a long shift is in flight
      in_valid = 1'b1;
      alu_op   = 4'b1000;
      op_a     = 32'h0000_0001;
      op_b     = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("abort_reset_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_reset_result", result, 32'd0);
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         if (out_valid) vcount++;
         @(posedge clk); #1;
      end
      chk("abort_no_valid", vcount, 0);
      run_op(4'b0000, 32'd2, 32'd3, 32'd5, 1, 0, "post_abort_add");

      // Randomized ops against the reference model
      corner[0] = 32'h0000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF;
      corner[4] = 32'h0000_0001;
      corner[5] = 32'hAAAA_5555;
      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         run_op(rop, ra, rb, ref_alu(rop, ra, rb), ref_lat(rop, rb),
                int'($urandom_range(0, 2)), $sformatf("rnd%0d_op%0d", n, rop));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
